// File: rtl/npc_pkg.sv
//------------------------------------------------------------------------------
// Module : npc_pkg
// Brief  : Shared types and constants for the instruction fetch path.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package npc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/inst_fetch.sv
//------------------------------------------------------------------------------
// Module : inst_fetch
// Brief  : Handshaked multi-cycle instruction fetch feeding a single-cycle core.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetch
    import npc_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    output logic [DATA_W-1:0] cmd,
    output logic              cmd_valid,
    output logic              pc_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              mem_resp_err,
    output logic              fetch_fault,
    output logic [63:0]       inst_cnt
);

    // The core boots from RESET_PC, so it must be a legal word address.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("inst_fetch: RESET_PC must be word aligned");
    end

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [DATA_W-1:0] r_cmd;
    logic              r_fault;
    logic [63:0]       r_inst_cnt;

    logic w_req_valid;
    logic w_cmd_valid;
    logic w_pc_wen;
    logic w_capture;

    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        w_cmd_valid  = 1'b0;
        w_pc_wen     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            FETCH: begin
                if (pc[1:0] != 2'b00) begin
                    w_next_state = FAULT;
                end else begin
                    w_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (mem_resp_err) begin
                        w_next_state = FAULT;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = EXEC;
                    end
                end
            end
            EXEC: begin
                w_cmd_valid = 1'b1;
                if (!stall) begin
                    w_pc_wen     = 1'b1;
                    w_next_state = FETCH;
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_cmd      <= DATA_W'(NOP_INST);
            r_fault    <= 1'b0;
            r_inst_cnt <= 64'd0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_cmd <= mem_resp_data;
            end
            if (w_next_state == FAULT) begin
                r_fault <= 1'b1;
            end
            if (w_pc_wen) begin
                r_inst_cnt <= r_inst_cnt + 64'd1;
            end
        end
    end

    // Reset must silence the handshake and PC update in the reset cycle itself,
    // whatever state the register happens to hold.
    assign mem_req_valid = w_req_valid & ~rst;
    assign cmd_valid     = w_cmd_valid & ~rst;
    assign pc_wen        = w_pc_wen & ~rst;
    assign mem_req_addr  = pc;
    assign cmd           = r_cmd;
    assign fetch_fault   = r_fault;
    assign inst_cnt      = r_inst_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
//------------------------------------------------------------------------------
// Module : tb_inst_fetch
// Brief  : Self-checking bench for inst_fetch: vector table, random fetches,
//          and hand sequences for reset, error and misalignment corners.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        pc_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        fetch_fault;
    logic [63:0] inst_cnt;

    inst_fetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .stall          (stall),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .pc_wen         (pc_wen),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .fetch_fault    (fetch_fault),
        .inst_cnt       (inst_cnt)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] m_cnt   = 64'd0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          ready_lat;
        int          resp_lat;
        int          stall_n;
        bit          spur;
        int          exp_wen;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        stall          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        mem_resp_err   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_cnt = 64'd0;
    endtask

    // One instruction: memory accepts after rl cycles, answers sl cycles after
    // acceptance, core stalls st EXEC cycles. Starts #1 after an edge in FETCH.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input int rl,
                           input int sl, input int st, input bit spur, input int exp_wen);
        int          acc     = -1;
        int          wen_c   = -1;
        int          first_v = -1;
        int          n_v     = 0;
        bit          bad_addr = 1'b0;
        logic [31:0] cmd_at  = 32'h0;
        pc = a;
        for (int c = 0; c < 40; c++) begin
            mem_req_ready  = (c >= rl);
            mem_resp_valid = (spur && c == 0) || (acc >= 0 && c == acc + sl);
            mem_resp_data  = (spur && c == 0) ? 32'hbad0_bad0 : d;
            mem_resp_err   = 1'b0;
            stall          = (c < exp_wen);
            @(negedge clk);
            if (mem_req_valid && mem_req_addr !== a) bad_addr = 1'b1;
            if (mem_req_valid && mem_req_ready && acc < 0) acc = c;
            if (cmd_valid) begin
                n_v++;
                if (first_v < 0) first_v = c;
            end
            if (pc_wen) begin
                wen_c  = c;
                cmd_at = cmd;
            end
            @(posedge clk);
            #1;
            if (wen_c >= 0) break;
        end
        idle_inputs();
        if (wen_c >= 0) m_cnt = m_cnt + 64'd1;
        check("accept_cycle", 64'(acc), 64'(rl));
        check("addr_stable", {63'd0, bad_addr}, 64'd0);
        check("first_cmd_valid", 64'(first_v), 64'(exp_wen - st));
        check("cmd_valid_cycles", 64'(n_v), 64'(st + 1));
        check("pc_wen_cycle", 64'(wen_c), 64'(exp_wen));
        check("cmd_at_wen", {32'd0, cmd_at}, {32'd0, d});
        check("inst_cnt", inst_cnt, m_cnt);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        vecs[0] = '{32'h8000_0000, 32'h0050_0093, 0, 1, 0, 1'b0, 2};
        vecs[1] = '{32'h8000_0004, 32'h00a0_0113, 3, 2, 0, 1'b0, 6};
        vecs[2] = '{32'h8000_0008, 32'h0020_81b3, 0, 1, 4, 1'b0, 6};
        vecs[3] = '{32'h8000_000c, 32'hfff0_0213, 1, 3, 1, 1'b1, 6};

        pc  = 32'h8000_0000;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd", {32'd0, cmd}, {32'd0, NOP_INST});
        check("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        check("rst_pc_wen", {63'd0, pc_wen}, 64'd0);
        check("rst_fault", {63'd0, fetch_fault}, 64'd0);
        check("rst_inst_cnt", inst_cnt, 64'd0);
        check("fetch_req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("fetch_req_addr", {32'd0, mem_req_addr}, 64'h8000_0000);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            run_txn(vecs[i].pc, vecs[i].data, vecs[i].ready_lat, vecs[i].resp_lat,
                    vecs[i].stall_n, vecs[i].spur, vecs[i].exp_wen);

        // Random fetches; expected pc_wen timing is 3 cycles plus every extra wait.
        rpc = 32'h8000_1000;
        for (int i = 0; i < 25; i++) begin
            int rl = $urandom_range(0, 4);
            int sl = $urandom_range(1, 4);
            int st = $urandom_range(0, 3);
            bit sp = (rl > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_txn(rpc, $urandom, rl, sl, st, sp, rl + sl + 1 + st);
            rpc = rpc + 32'd4;
        end

        // Reset while waiting for a response; the late response must be dropped.
        pc = 32'h8000_0100;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("rw_req_valid", {63'd0, mem_req_valid}, 64'd1);
        @(posedge clk);
        #1;
        mem_req_ready  = 1'b0;
        rst            = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hdead_beef;
        @(negedge clk);
        check("rw_rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rw_rst_pc_wen", {63'd0, pc_wen}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        m_cnt = 64'd0;
        @(negedge clk);
        check("rw_cmd", {32'd0, cmd}, {32'd0, NOP_INST});
        check("rw_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        check("rw_inst_cnt", inst_cnt, 64'd0);
        check("rw_fetch_again", {63'd0, mem_req_valid}, 64'd1);
        @(posedge clk);
        #1;
        run_txn(32'h8000_0100, 32'h0010_0293, 0, 1, 0, 1'b0, 2);

        // Error response: fault, command untouched, further responses ignored.
        do_reset();
        pc = 32'h8000_0200;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_err   = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("err_fault", {63'd0, fetch_fault}, 64'd1);
        check("err_cmd", {32'd0, cmd}, {32'd0, NOP_INST});
        check("err_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        check("err_req_valid", {63'd0, mem_req_valid}, 64'd0);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0093;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", {63'd0, fetch_fault}, 64'd1);
        check("err_cmd_hold", {32'd0, cmd}, {32'd0, NOP_INST});
        check("err_pc_wen", {63'd0, pc_wen}, 64'd0);

        // Misaligned PC: no request, fault next cycle, sticky until reset.
        do_reset();
        pc = 32'h8000_0002;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("mis_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("mis_fault_early", {63'd0, fetch_fault}, 64'd0);
        @(posedge clk);
        #1;
        pc = 32'h8000_0004;
        @(negedge clk);
        check("mis_fault", {63'd0, fetch_fault}, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mis_sticky", {63'd0, fetch_fault}, 64'd1);
        check("mis_no_req", {63'd0, mem_req_valid}, 64'd0);
        check("mis_inst_cnt", inst_cnt, 64'd0);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("mis_cleared", {63'd0, fetch_fault}, 64'd0);
        check("mis_req_after", {63'd0, mem_req_valid}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
